// File: rtl/pe_pkg.sv
// Shared types for the PE control sequencer: FSM state encoding and datapath pipeline depth.
package pe_pkg;
    localparam int PIPE_DEPTH = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        CLEAR,
        MAC,
        ACC,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/pe_ctrl_if.sv
// Control/handshake bundle between the network side (master) and the PE sequencer (slave).
interface pe_ctrl_if #(
    parameter int IFMAP_SPAD_AWIDTH = 4,
    parameter int WGHT_SPAD_AWIDTH  = 7,
    parameter int PSUM_SPAD_AWIDTH  = 3
);
    logic                          i_start;
    logic                          i_load_wght;
    logic [IFMAP_SPAD_AWIDTH:0]    i_cfg_s;
    logic [PSUM_SPAD_AWIDTH:0]     i_cfg_p;
    logic                          i_wght_valid;
    logic                          o_wght_ready;
    logic                          i_ifmap_valid;
    logic                          o_ifmap_ready;
    logic                          i_psum_in_valid;
    logic                          o_psum_in_ready;
    logic [IFMAP_SPAD_AWIDTH-1:0]  o_ifmap_spad_addr;
    logic [WGHT_SPAD_AWIDTH-1:0]   o_wght_spad_addr;
    logic [PSUM_SPAD_AWIDTH-1:0]   o_psum_spad_addr;
    logic                          o_ifmap_spad_we;
    logic                          o_wght_spad_we;
    logic                          o_psum_spad_we;
    logic                          o_acc_sel;
    logic                          o_rst_psum;
    logic                          o_busy;
    logic                          o_done;

    modport master (
        output i_start, i_load_wght, i_cfg_s, i_cfg_p,
        output i_wght_valid, i_ifmap_valid, i_psum_in_valid,
        input  o_wght_ready, o_ifmap_ready, o_psum_in_ready,
        input  o_ifmap_spad_addr, o_wght_spad_addr, o_psum_spad_addr,
        input  o_ifmap_spad_we, o_wght_spad_we, o_psum_spad_we,
        input  o_acc_sel, o_rst_psum, o_busy, o_done
    );

    modport slave (
        input  i_start, i_load_wght, i_cfg_s, i_cfg_p,
        input  i_wght_valid, i_ifmap_valid, i_psum_in_valid,
        output o_wght_ready, o_ifmap_ready, o_psum_in_ready,
        output o_ifmap_spad_addr, o_wght_spad_addr, o_psum_spad_addr,
        output o_ifmap_spad_we, o_wght_spad_we, o_psum_spad_we,
        output o_acc_sel, o_rst_psum, o_busy, o_done
    );
endinterface

// File: rtl/pe_loop_cnt.sv
// Nested filter (f, outer) / tap (k, inner) counter with registered linear index f*S+k.
// last_k flags the final tap of a row, last flags the final filter row; the loop wraps to 0 on both.
module pe_loop_cnt #(
    parameter int KW = 4,
    parameter int FW = 3,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [KW:0]   bound_k,
    input  logic [FW:0]   bound_f,
    output logic [KW-1:0] k,
    output logic [FW-1:0] f,
    output logic [IW-1:0] idx,
    output logic          last_k,
    output logic          last
);
    assign last_k = ({1'b0, k} == (bound_k - (KW+1)'(1)));
    assign last   = ({1'b0, f} == (bound_f - (FW+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k   <= '0;
            f   <= '0;
            idx <= '0;
        end else if (en) begin
            if (last_k && last) begin
                k   <= '0;
                f   <= '0;
                idx <= '0;
            end else if (last_k) begin
                k   <= '0;
                f   <= f + FW'(1);
                idx <= idx + IW'(1);
            end else begin
                k   <= k + KW'(1);
                idx <= idx + IW'(1);
            end
        end
    end
endmodule

// File: rtl/pe_ctrl.sv
// PE control sequencer: load weights/ifmap, clear psums, MAC, accumulate upstream psums, drain.
// Ready/we are combinational from state and valid; addresses come straight from registered counters.
module pe_ctrl #(
    parameter int IFMAP_SPAD_AWIDTH = 4,
    parameter int WGHT_SPAD_AWIDTH  = 7,
    parameter int PSUM_SPAD_AWIDTH  = 3,
    parameter int PIPE_DEPTH        = pe_pkg::PIPE_DEPTH
) (
    input logic      i_clk,
    input logic      i_rst,
    pe_ctrl_if.slave bus
);
    import pe_pkg::*;

    localparam int WI = WGHT_SPAD_AWIDTH + 1;
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    state_t state, state_nxt;

    logic [IFMAP_SPAD_AWIDTH:0]   s_q;
    logic [PSUM_SPAD_AWIDTH:0]    p_q;
    logic [WI-1:0]                ps_q;
    logic [IFMAP_SPAD_AWIDTH-1:0] icnt, lk;
    logic [PSUM_SPAD_AWIDTH-1:0]  pcnt, lf;
    logic [WI-1:0]                lidx;
    logic [DW-1:0]                dcnt;
    logic                         lp_last_k, lp_last, loop_end;
    logic                         start_ok, wght_hs, ifmap_hs, acc_hs;
    logic                         last_w, last_i, last_p, last_d;

    assign start_ok = bus.i_start && (bus.i_cfg_s != '0) && (bus.i_cfg_p != '0);
    assign wght_hs  = (state == LOAD_W) && bus.i_wght_valid;
    assign ifmap_hs = (state == LOAD_I) && bus.i_ifmap_valid;
    assign acc_hs   = (state == ACC) && bus.i_psum_in_valid;

    assign loop_end = lp_last_k && lp_last;
    // Full-width compare so P*S = 2^WGHT_SPAD_AWIDTH terminates cleanly.
    assign last_w   = (lidx == (ps_q - WI'(1)));
    assign last_i   = ({1'b0, icnt} == (s_q - (IFMAP_SPAD_AWIDTH+1)'(1)));
    assign last_p   = ({1'b0, pcnt} == (p_q - (PSUM_SPAD_AWIDTH+1)'(1)));
    assign last_d   = (dcnt == DW'(PIPE_DEPTH - 1));

    pe_loop_cnt #(
        .KW (IFMAP_SPAD_AWIDTH),
        .FW (PSUM_SPAD_AWIDTH),
        .IW (WI)
    ) u_loop (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (state == IDLE),
        .en      ((state == MAC) || wght_hs),
        .bound_k (s_q),
        .bound_f (p_q),
        .k       (lk),
        .f       (lf),
        .idx     (lidx),
        .last_k  (lp_last_k),
        .last    (lp_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_q  <= '0;
            p_q  <= '0;
            ps_q <= '0;
            icnt <= '0;
            pcnt <= '0;
            dcnt <= '0;
        end else begin
            if ((state == IDLE) && start_ok) begin
                s_q  <= bus.i_cfg_s;
                p_q  <= bus.i_cfg_p;
                ps_q <= WI'(bus.i_cfg_s) * WI'(bus.i_cfg_p);
            end
            if (ifmap_hs) icnt <= last_i ? '0 : icnt + IFMAP_SPAD_AWIDTH'(1);
            if ((state == CLEAR) || acc_hs)
                pcnt <= last_p ? '0 : pcnt + PSUM_SPAD_AWIDTH'(1);
            if (state == DRAIN) dcnt <= last_d ? '0 : dcnt + DW'(1);
        end
    end

    always_comb begin
        state_nxt           = state;
        bus.o_wght_ready    = 1'b0;
        bus.o_ifmap_ready   = 1'b0;
        bus.o_psum_in_ready = 1'b0;
        bus.o_wght_spad_we  = 1'b0;
        bus.o_ifmap_spad_we = 1'b0;
        bus.o_psum_spad_we  = 1'b0;
        bus.o_acc_sel       = 1'b0;
        bus.o_rst_psum      = 1'b0;
        bus.o_done          = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = bus.i_load_wght ? LOAD_W : LOAD_I;
            LOAD_W: begin
                bus.o_wght_ready   = 1'b1;
                bus.o_wght_spad_we = bus.i_wght_valid;
                if (wght_hs && last_w) state_nxt = LOAD_I;
            end
            LOAD_I: begin
                bus.o_ifmap_ready   = 1'b1;
                bus.o_ifmap_spad_we = bus.i_ifmap_valid;
                if (ifmap_hs && last_i) state_nxt = CLEAR;
            end
            CLEAR: begin
                bus.o_rst_psum     = 1'b1;
                bus.o_psum_spad_we = 1'b1;
                if (last_p) state_nxt = MAC;
            end
            MAC: begin
                bus.o_psum_spad_we = 1'b1;
                if (loop_end) state_nxt = ACC;
            end
            ACC: begin
                bus.o_psum_in_ready = 1'b1;
                bus.o_acc_sel       = bus.i_psum_in_valid;
                bus.o_psum_spad_we  = bus.i_psum_in_valid;
                if (acc_hs && last_p) state_nxt = DRAIN;
            end
            DRAIN: if (last_d) state_nxt = DONE;
            DONE: begin
                bus.o_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_busy            = (state != IDLE);
    assign bus.o_ifmap_spad_addr = (state == MAC) ? lk : icnt;
    assign bus.o_psum_spad_addr  = (state == MAC) ? lf : pcnt;
    assign bus.o_wght_spad_addr  = lidx[WGHT_SPAD_AWIDTH-1:0];
endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with a behavioural PE datapath attached to the spad controls.
module tb_pe_ctrl;
    localparam int IA = 4;
    localparam int WA = 7;
    localparam int PA = 3;
    localparam int PD = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_ctrl_if #(.IFMAP_SPAD_AWIDTH(IA), .WGHT_SPAD_AWIDTH(WA), .PSUM_SPAD_AWIDTH(PA)) bus ();

    pe_ctrl #(
        .IFMAP_SPAD_AWIDTH (IA),
        .WGHT_SPAD_AWIDTH  (WA),
        .PSUM_SPAD_AWIDTH  (PA),
        .PIPE_DEPTH        (PD)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    logic [23:0] outs;
    assign outs = {bus.o_wght_ready, bus.o_ifmap_ready, bus.o_psum_in_ready,
                   bus.o_ifmap_spad_addr, bus.o_wght_spad_addr, bus.o_psum_spad_addr,
                   bus.o_ifmap_spad_we, bus.o_wght_spad_we, bus.o_psum_spad_we,
                   bus.o_acc_sel, bus.o_rst_psum, bus.o_busy, bus.o_done};

    typedef struct {
        bit vld;
        bit acc;
        bit rp;
        int pa;
        int prod;
        int pin;
    } stage_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int wght_sp[128];
    int ifmap_sp[16];
    int psum_sp[8];
    stage_t pipe[3];

    int wdat[$], idat[$], pdat[$];
    int w_idx, i_idx, p_idx;
    int w_addr_q[$], i_addr_q[$], clr_q[$], mac_q[$], acc_cyc_q[$];
    int out_q[$], out_cyc_q[$], done_q[$];
    int wrdy_cnt;

    task automatic clear_logs();
        w_idx = 0; i_idx = 0; p_idx = 0; wrdy_cnt = 0;
        w_addr_q.delete(); i_addr_q.delete(); clr_q.delete(); mac_q.delete();
        acc_cyc_q.delete(); out_q.delete(); out_cyc_q.delete(); done_q.delete();
    endtask

    // One clock cycle: sample the control outputs, run the datapath model, advance to the next negedge.
    task automatic tick();
        stage_t cur;
        int r;
        #1;
        if (pipe[2].vld) begin
            r = pipe[2].rp ? 0 : psum_sp[pipe[2].pa] + (pipe[2].acc ? pipe[2].pin : pipe[2].prod);
            psum_sp[pipe[2].pa] = r;
            if (pipe[2].acc) begin
                out_q.push_back(r);
                out_cyc_q.push_back(cyc);
            end
        end
        cur = '{default: 0};
        cur.vld  = bus.o_psum_spad_we;
        cur.acc  = bus.o_acc_sel;
        cur.rp   = bus.o_rst_psum;
        cur.pa   = int'(bus.o_psum_spad_addr);
        cur.prod = ifmap_sp[bus.o_ifmap_spad_addr] * wght_sp[bus.o_wght_spad_addr];
        if (bus.i_psum_in_valid && bus.o_psum_in_ready) begin
            cur.pin = (p_idx < pdat.size()) ? pdat[p_idx] : 0;
            p_idx++;
        end
        if (bus.o_wght_spad_we) begin
            wght_sp[bus.o_wght_spad_addr] = (w_idx < wdat.size()) ? wdat[w_idx] : 0;
            w_idx++;
            w_addr_q.push_back(int'(bus.o_wght_spad_addr));
        end
        if (bus.o_ifmap_spad_we) begin
            ifmap_sp[bus.o_ifmap_spad_addr] = (i_idx < idat.size()) ? idat[i_idx] : 0;
            i_idx++;
            i_addr_q.push_back(int'(bus.o_ifmap_spad_addr));
        end
        if (bus.o_psum_spad_we && bus.o_rst_psum) clr_q.push_back(cur.pa);
        if (bus.o_psum_spad_we && !bus.o_rst_psum && !bus.o_acc_sel)
            mac_q.push_back((int'(bus.o_ifmap_spad_addr) << 16) |
                            (int'(bus.o_wght_spad_addr) << 8) | cur.pa);
        if (bus.o_psum_spad_we && bus.o_acc_sel) acc_cyc_q.push_back(cyc);
        if (bus.o_wght_ready) wrdy_cnt++;
        if (bus.o_done) done_q.push_back(cyc);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = cur;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_pass(input int s, input int p, input bit ld, output int t0);
        bus.i_cfg_s = 5'(s);
        bus.i_cfg_p = 4'(p);
        bus.i_load_wght = ld;
        bus.i_start = 1'b1;
        t0 = cyc;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic run_to_done(input int limit);
        for (int i = 0; i < limit && done_q.size() == 0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b1; bus.i_load_wght = 1'b1; bus.i_cfg_s = 5'd3; bus.i_cfg_p = 4'd2;
        bus.i_wght_valid = 1'b0; bus.i_ifmap_valid = 1'b0; bus.i_psum_in_valid = 1'b0;
        tick(); tick(); tick();
        n_chk++;
        if (outs !== 24'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 000000", outs); end
        rst = 1'b0;
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", bus.o_busy); end
        tick();
        n_chk++;
        if (bus.o_busy !== 1'b1 || bus.o_wght_ready !== 1'b1)
            begin n_fail++; $display("FAIL start_after_reset: busy %b wght_ready %b expected 1 1", bus.o_busy, bus.o_wght_ready); end
        bus.i_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (outs !== 24'h0) begin n_fail++; $display("FAIL reset_reabort: got %h expected 000000", outs); end
    endtask

    task automatic test_full_pass();
        int t0;
        int exp_mac[6] = '{(0<<16)|(0<<8)|0, (1<<16)|(1<<8)|0, (2<<16)|(2<<8)|0,
                           (0<<16)|(3<<8)|1, (1<<16)|(4<<8)|1, (2<<16)|(5<<8)|1};
        int got;
        clear_logs();
        wdat = '{1, 1, 1, 2, 0, 1}; idat = '{1, 2, 3}; pdat = '{10, 20};
        bus.i_wght_valid = 1'b1; bus.i_ifmap_valid = 1'b1; bus.i_psum_in_valid = 1'b1;
        start_pass(3, 2, 1'b1, t0);
        bus.i_cfg_s = 5'd5; bus.i_cfg_p = 4'd1;
        run_to_done(60);
        n_chk++;
        if (w_addr_q.size() != 6) begin n_fail++; $display("FAIL wght_write_count: got %0d expected 6", w_addr_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < w_addr_q.size()) ? w_addr_q[i] : -1;
            n_chk++;
            if (got !== i) begin n_fail++; $display("FAIL wght_addr[%0d]: got %0d expected %0d", i, got, i); end
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < i_addr_q.size()) ? i_addr_q[i] : -1;
            n_chk++;
            if (got !== i) begin n_fail++; $display("FAIL ifmap_addr[%0d]: got %0d expected %0d", i, got, i); end
        end
        n_chk++;
        if (clr_q.size() != 2 || clr_q[0] != 0 || clr_q[1] != 1)
            begin n_fail++; $display("FAIL clear_cycles: got %0d writes expected 2 at addr 0,1", clr_q.size()); end
        n_chk++;
        if (mac_q.size() != 6) begin n_fail++; $display("FAIL mac_count: got %0d expected 6", mac_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < mac_q.size()) ? mac_q[i] : -1;
            n_chk++;
            if (got !== exp_mac[i]) begin n_fail++; $display("FAIL mac_kwf[%0d]: got %h expected %h", i, got, exp_mac[i]); end
        end
        got = (done_q.size() == 1) ? done_q[0] - t0 : -1;
        n_chk++;
        if (got !== 23) begin n_fail++; $display("FAIL full_done_latency: got %0d expected 23", got); end
        n_chk++;
        if (out_q.size() != 2 || out_q[0] != 16 || out_q[1] != 25)
            begin n_fail++; $display("FAIL full_psum_out: got %0d results first %0d expected 16 25", out_q.size(), (out_q.size() > 0) ? out_q[0] : -1); end
        n_chk++;
        if (out_cyc_q.size() != 2 || done_q.size() != 1 || out_cyc_q[1] + 1 != done_q[0])
            begin n_fail++; $display("FAIL done_after_last_out: done count %0d expected one cycle after last psum out", done_q.size()); end
    endtask

    task automatic test_acc_gaps();
        int t0, got, acc_n;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_logs();
        idat = '{1, 2, 3}; pdat = '{10, 20};
        bus.i_wght_valid = 1'b1; bus.i_ifmap_valid = 1'b1; bus.i_psum_in_valid = 1'b0;
        acc_n = 0;
        start_pass(3, 2, 1'b0, t0);
        for (int i = 0; i < 60 && done_q.size() == 0; i++) begin
            if (bus.o_psum_in_ready && acc_n < 4) begin
                bus.i_psum_in_valid = pat[acc_n];
                #1;
                n_chk++;
                if (bus.o_psum_spad_we !== pat[acc_n] || bus.o_acc_sel !== pat[acc_n])
                    begin n_fail++; $display("FAIL acc_we[%0d]: we %b acc_sel %b expected %b", acc_n, bus.o_psum_spad_we, bus.o_acc_sel, pat[acc_n]); end
                acc_n++;
            end else begin
                bus.i_psum_in_valid = 1'b0;
            end
            tick();
        end
        n_chk++;
        if (wrdy_cnt !== 0 || w_addr_q.size() != 0)
            begin n_fail++; $display("FAIL no_wght_load: ready cycles %0d writes %0d expected 0 0", wrdy_cnt, w_addr_q.size()); end
        got = (done_q.size() == 1) ? done_q[0] - t0 : -1;
        n_chk++;
        if (got !== 19) begin n_fail++; $display("FAIL gap_done_latency: got %0d expected 19", got); end
        got = (acc_cyc_q.size() == 2 && done_q.size() == 1) ? done_q[0] - acc_cyc_q[1] : -1;
        n_chk++;
        if (got !== PD + 1) begin n_fail++; $display("FAIL done_after_acc: got %0d expected %0d", got, PD + 1); end
        n_chk++;
        if (out_q.size() != 2 || out_q[0] != 16 || out_q[1] != 25)
            begin n_fail++; $display("FAIL reuse_psum_out: got %0d results first %0d expected 16 25", out_q.size(), (out_q.size() > 0) ? out_q[0] : -1); end
    endtask

    task automatic test_abort();
        int t0;
        clear_logs();
        idat = '{1, 2, 3}; pdat = '{10, 20};
        bus.i_ifmap_valid = 1'b1; bus.i_psum_in_valid = 1'b1;
        start_pass(3, 2, 1'b0, t0);
        for (int i = 0; i < 20 && mac_q.size() == 0; i++) tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (mac_q.size() < 1) begin n_fail++; $display("FAIL abort_reached_mac: got %0d mac cycles expected >0", mac_q.size()); end
        n_chk++;
        if (outs !== 24'h0) begin n_fail++; $display("FAIL abort_outputs: got %h expected 000000", outs); end
        repeat (40) tick();
        n_chk++;
        if (done_q.size() != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_q.size()); end
        bus.i_cfg_s = 5'd3; bus.i_cfg_p = 4'd0; bus.i_start = 1'b1;
        tick(); tick();
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL start_p0: busy %b expected 0", bus.o_busy); end
        bus.i_cfg_s = 5'd0; bus.i_cfg_p = 4'd2;
        tick(); tick();
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL start_s0: busy %b expected 0", bus.o_busy); end
        bus.i_start = 1'b0;
    endtask

    task automatic test_max_cfg();
        int t0, got, e;
        clear_logs();
        wdat.delete(); idat.delete(); pdat.delete();
        for (int i = 0; i < 128; i++) wdat.push_back((i * 7) % 5);
        for (int i = 0; i < 16; i++) idat.push_back(i % 4 + 1);
        for (int i = 0; i < 8; i++) pdat.push_back(100 * i);
        bus.i_wght_valid = 1'b1; bus.i_ifmap_valid = 1'b1; bus.i_psum_in_valid = 1'b1;
        start_pass(16, 8, 1'b1, t0);
        run_to_done(400);
        got = (w_addr_q.size() == 128) ? w_addr_q[127] : -1;
        n_chk++;
        if (got !== 127) begin n_fail++; $display("FAIL max_wght_last: got %0d expected 127 (writes %0d)", got, w_addr_q.size()); end
        got = (mac_q.size() == 128) ? mac_q[127] : -1;
        n_chk++;
        if (got !== ((15 << 16) | (127 << 8) | 7)) begin n_fail++; $display("FAIL max_mac_last: got %h expected %h", got, (15 << 16) | (127 << 8) | 7); end
        got = (done_q.size() == 1) ? done_q[0] - t0 : -1;
        n_chk++;
        if (got !== 292) begin n_fail++; $display("FAIL max_done_latency: got %0d expected 292", got); end
        for (int f = 0; f < 8; f++) begin
            e = pdat[f];
            for (int k = 0; k < 16; k++) e += wdat[f * 16 + k] * idat[k];
            got = (f < out_q.size()) ? out_q[f] : -1;
            n_chk++;
            if (got !== e) begin n_fail++; $display("FAIL max_psum_out[%0d]: got %0d expected %0d", f, got, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        for (int i = 0; i < 128; i++) wght_sp[i] = 0;
        for (int i = 0; i < 16; i++) ifmap_sp[i] = 0;
        for (int i = 0; i < 8; i++) psum_sp[i] = 0;
        clear_logs();
        test_reset();
        test_full_pass();
        test_acc_gaps();
        test_abort();
        test_max_cfg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
